// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
//  Shared encodings and defaults for the multi-channel tick generator:
//  channel mode (periodic / one-shot), one-shot FSM states, default
//  counter width and reset period, and the channel-select width helper.
package tick_gen_pkg;

    localparam int DEF_CNT_W      = 14;
    localparam int DEF_PERIOD_VAL = 10000;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if
//  Configuration, control and status bundle of tick_gen.
//  master: the controller (drives cfg_*, ch_en, ch_start; reads tick, busy, cnt)
//  slave : tick_gen itself
//  cfg_we/cfg_ch/cfg_period/cfg_mode : one-cycle config write of one channel
//  ch_en    : per-channel count enable (level)
//  ch_start : per-channel start / restart pulse
//  tick     : registered one-cycle strobe per channel
//  busy     : channel counting
//  cnt      : packed counter values, channel 0 in the LSBs
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int CH_W = ch_width(NUM_CH);

    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [CNT_W-1:0]        cfg_period;
    logic                    cfg_mode;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_start;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH*CNT_W-1:0] cnt;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_mode, ch_en, ch_start,
        input  tick, busy, cnt
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_mode, ch_en, ch_start,
        output tick, busy, cnt
    );

endinterface

// File: rtl/tick_gen_chan.sv
// tick_gen_chan
//  One tick channel: period and mode registers, counter and one-shot FSM.
//  Ports:
//   clk, rst       clock, asynchronous active-low reset
//   cfg_load       config write addressed to this channel
//   cfg_period     new period P
//   cfg_mode       0 = periodic, 1 = one-shot
//   en             count enable (level)
//   start          start / restart pulse
//   step_ok        extra count qualifier (cascade input, 1 when unused)
//   fire           combinational: the tick register loads 1 on this edge
//   busy           channel counting
//   cnt            current counter value
module tick_gen_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             en,
    input  logic             start,
    input  logic             step_ok,
    output logic             fire,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] period;
    mode_t            mode;
    state_t           state;
    state_t           state_nxt;
    logic             active;
    logic             step;
    logic             at_end;

    // Next-state and strobe logic. A config write beats a start, which beats
    // a count step; only a step taken at cnt==P produces a tick.
    always_comb begin
        state_nxt = state;
        active    = (mode == MODE_PERIODIC) || (state == ST_RUN);
        step      = en && active && step_ok;
        at_end    = (cnt == period);
        fire      = step && at_end && !cfg_load && !start;
        // busy is forced low while reset is asserted, even if en is high.
        busy      = rst && ((mode == MODE_PERIODIC) ? en : (state == ST_RUN));

        if (cfg_load) begin
            state_nxt = ST_IDLE;
        end else if (start) begin
            if (mode == MODE_ONESHOT) begin
                state_nxt = ST_RUN;
            end
        end else if (fire && (mode == MODE_ONESHOT)) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Period/mode registers and counter. The counter only ever resets or
    // counts up to P, so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period <= CNT_W'(DEF_PERIOD);
            mode   <= MODE_PERIODIC;
            cnt    <= '0;
        end else if (cfg_load) begin
            period <= cfg_period;
            mode   <= mode_t'(cfg_mode);
            cnt    <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= at_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_gen.sv
// tick_gen
//  Multi-channel programmable tick generator. Each channel strobes tick
//  every P+1 enabled clocks (periodic) or once per start (one-shot).
//  Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   tick_gen_if.slave: config write, ch_en, ch_start in; tick, busy,
//         cnt out
//  Build option TICK_GEN_CASCADE_EN: channel i>0 advances only on edges
//  where channel i-1 ticks, so its interval is the product of (P_k+1).
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_VAL
) (
    input logic       clk,
    input logic       rst,
    tick_gen_if.slave bus
);

    logic [NUM_CH-1:0]       load;
    logic [NUM_CH-1:0]       fire;
    logic [NUM_CH-1:0]       step_ok;
    logic [NUM_CH-1:0]       busy_w;
    logic [NUM_CH*CNT_W-1:0] cnt_w;
    logic [NUM_CH-1:0]       tick_q;

    // Channel select decode; codes at or above NUM_CH match nothing.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = bus.cfg_we && (32'(bus.cfg_ch) == 32'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef TICK_GEN_CASCADE_EN
        // Cascade from the lower channel's same-edge tick, so a cascaded
        // tick coincides with the tick of the channel feeding it.
        if (g == 0) begin : g_head
            assign step_ok[g] = 1'b1;
        end else begin : g_link
            assign step_ok[g] = fire[g-1];
        end
`else
        assign step_ok[g] = 1'b1;
`endif

        tick_gen_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .cfg_load   (load[g]),
            .cfg_period (bus.cfg_period),
            .cfg_mode   (bus.cfg_mode),
            .en         (bus.ch_en[g]),
            .start      (bus.ch_start[g]),
            .step_ok    (step_ok[g]),
            .fire       (fire[g]),
            .busy       (busy_w[g]),
            .cnt        (cnt_w[g*CNT_W +: CNT_W])
        );
    end

    // Registered tick strobes for all channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= fire;
        end
    end

    assign bus.tick = tick_q;
    assign bus.busy = busy_w;
    assign bus.cnt  = cnt_w;

endmodule
